// File: rtl/spi_slave_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_fsm_if
//  Description : Bundle of SPI serial lines plus the RAM-side rx/tx handshake
//                used by spi_slave_fsm.
//                slave  modport : the SPI slave front end (spi_slave_fsm).
//                master modport : whatever drives the serial frame and
//                                 answers read requests (SPI master + RAM).
//  Signals     : SS_n     - frame select, active-low
//                MOSI     - serial data toward the slave
//                MISO     - serial data from the slave
//                tx_data  - RAM read data, ADDR_SIZE bits
//                tx_valid - RAM read data valid (level)
//                rx_data  - received frame {cmd[1:0], payload}
//                rx_valid - one-cycle pulse qualifying rx_data
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_slave_fsm_if #(
    parameter int ADDR_SIZE = 8
) ();
    logic                 SS_n;
    logic                 MOSI;
    logic                 MISO;
    logic [ADDR_SIZE-1:0] tx_data;
    logic                 tx_valid;
    logic [ADDR_SIZE+1:0] rx_data;
    logic                 rx_valid;

    modport slave (
        input  SS_n,
        input  MOSI,
        input  tx_data,
        input  tx_valid,
        output MISO,
        output rx_data,
        output rx_valid
    );

    modport master (
        output SS_n,
        output MOSI,
        output tx_data,
        output tx_valid,
        input  MISO,
        input  rx_data,
        input  rx_valid
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_fsm
//  Description : SPI slave front end for the single-port RAM stage.
//                Deserialises MOSI frames of ADDR_SIZE+2 bits into rx_data
//                with a one-cycle rx_valid pulse; for read-data commands it
//                captures the RAM answer (tx_data/tx_valid) once and shifts
//                it out MSB-first on MISO. clk is the SPI serial clock.
//  Ports       : clk         - serial/system clock, rising edge
//                rst_n       - asynchronous active-low reset
//                bus         - spi_slave_fsm_if.slave (SS_n, MOSI, MISO,
//                              tx_data, tx_valid, rx_data, rx_valid)
//                timeout_err - sticky "RAM never answered" flag
//                              (only when SPI_TX_TIMEOUT_EN is defined)
//  Options     : SPI_TX_TIMEOUT_EN - enables TIMEOUT_CYCLES, the READ_DATA
//                wait counter and the timeout_err port.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_fsm #(
    parameter int ADDR_SIZE = 8
`ifdef SPI_TX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 15
`endif
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
`ifdef SPI_TX_TIMEOUT_EN
    output logic           timeout_err,
`endif
    spi_slave_fsm_if.slave bus
);

    localparam int FRAME_W = ADDR_SIZE + 2;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int TXC_W   = $clog2(ADDR_SIZE + 1);
`ifdef SPI_TX_TIMEOUT_EN
    localparam int WAIT_W  = $clog2(TIMEOUT_CYCLES + 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CHK_CMD   = 3'd1,
        S_WRITE     = 3'd2,
        S_READ_ADD  = 3'd3,
        S_READ_DATA = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    // Holds the bits received so far; the final bit is merged in directly
    // when the frame completes, so one bit less than the frame is enough.
    logic [FRAME_W-2:0]   shift_q, shift_d;
    logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_done_q, rx_done_d;     // full frame received
    logic                 rd_addr_seen_q, rd_addr_seen_d;
    logic                 tx_latched_q, tx_latched_d;
    logic                 tx_done_q, tx_done_d;     // no further capture this frame
    // MSB goes straight to MISO at capture; only the rest is kept.
    logic [ADDR_SIZE-2:0] tx_shift_q, tx_shift_d;
    logic [TXC_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic                 miso_q, miso_d;
`ifdef SPI_TX_TIMEOUT_EN
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                 timeout_err_q, timeout_err_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            shift_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_done_q      <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            tx_latched_q   <= 1'b0;
            tx_done_q      <= 1'b0;
            tx_shift_q     <= '0;
            tx_cnt_q       <= '0;
            miso_q         <= 1'b0;
`ifdef SPI_TX_TIMEOUT_EN
            wait_cnt_q     <= '0;
            timeout_err_q  <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shift_q        <= shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_done_q      <= rx_done_d;
            rd_addr_seen_q <= rd_addr_seen_d;
            tx_latched_q   <= tx_latched_d;
            tx_done_q      <= tx_done_d;
            tx_shift_q     <= tx_shift_d;
            tx_cnt_q       <= tx_cnt_d;
            miso_q         <= miso_d;
`ifdef SPI_TX_TIMEOUT_EN
            wait_cnt_q     <= wait_cnt_d;
            timeout_err_q  <= timeout_err_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        shift_d        = shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rx_done_d      = rx_done_q;
        rd_addr_seen_d = rd_addr_seen_q;
        tx_latched_d   = tx_latched_q;
        tx_done_d      = tx_done_q;
        tx_shift_d     = tx_shift_q;
        tx_cnt_d       = tx_cnt_q;
        miso_d         = 1'b0;
`ifdef SPI_TX_TIMEOUT_EN
        wait_cnt_d     = wait_cnt_q;
        timeout_err_d  = timeout_err_q;
`endif

        if ((state_q != S_IDLE) && bus.SS_n) begin
            // Frame aborted: drop any partial frame, keep rd_addr_seen so a
            // read-address already accepted still routes the next read.
            state_d      = S_IDLE;
            cnt_d        = '0;
            rx_done_d    = 1'b0;
            tx_latched_d = 1'b0;
            tx_done_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d        = '0;
                    rx_done_d    = 1'b0;
                    tx_latched_d = 1'b0;
                    tx_done_d    = 1'b0;
                    if (!bus.SS_n) begin
                        state_d = S_CHK_CMD;
`ifdef SPI_TX_TIMEOUT_EN
                        wait_cnt_d    = '0;
                        timeout_err_d = 1'b0;
`endif
                    end
                end

                S_CHK_CMD: begin
                    shift_d   = {{(FRAME_W-2){1'b0}}, bus.MOSI};
                    cnt_d     = CNT_W'(1);
                    rx_done_d = 1'b0;
                    if (!bus.MOSI) begin
                        state_d = S_WRITE;
                    end else if (!rd_addr_seen_q) begin
                        state_d = S_READ_ADD;
                    end else begin
                        state_d = S_READ_DATA;
                    end
                end

                S_WRITE, S_READ_ADD, S_READ_DATA: begin
                    if (!rx_done_q) begin
                        shift_d = {shift_q[FRAME_W-3:0], bus.MOSI};
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                            rx_data_d  = {shift_q, bus.MOSI};
                            rx_valid_d = 1'b1;
                            rx_done_d  = 1'b1;
                            if (state_q == S_READ_ADD) begin
                                rd_addr_seen_d = 1'b1;
                            end
                        end
                    end else if (state_q == S_READ_DATA) begin
                        if (tx_latched_q) begin
                            if (tx_cnt_q == TXC_W'(ADDR_SIZE)) begin
                                // Last bit has been on MISO for a cycle.
                                tx_latched_d   = 1'b0;
                                rd_addr_seen_d = 1'b0;
                                tx_done_d      = 1'b1;
                            end else begin
                                miso_d     = tx_shift_q[ADDR_SIZE-2];
                                tx_shift_d = {tx_shift_q[ADDR_SIZE-3:0], 1'b0};
                                tx_cnt_d   = tx_cnt_q + 1'b1;
                            end
                        end else if (!tx_done_q) begin
                            // No capture in the rx_valid cycle itself, so the
                            // RAM always sees the request before we sample it.
                            if (bus.tx_valid && !rx_valid_q) begin
                                tx_latched_d = 1'b1;
                                miso_d       = bus.tx_data[ADDR_SIZE-1];
                                tx_shift_d   = bus.tx_data[ADDR_SIZE-2:0];
                                tx_cnt_d     = TXC_W'(1);
                            end
`ifdef SPI_TX_TIMEOUT_EN
                            else begin
                                wait_cnt_d = wait_cnt_q + 1'b1;
                                if (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                                    timeout_err_d  = 1'b1;
                                    tx_done_d      = 1'b1;
                                    tx_latched_d   = 1'b0;
                                    rd_addr_seen_d = 1'b0;
                                end
                            end
`endif
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.MISO     = miso_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
`ifdef SPI_TX_TIMEOUT_EN
    assign timeout_err  = timeout_err_q;
`endif

endmodule
`default_nettype wire

// File: doc/spi_slave_fsm.md
Name: spi_slave_fsm

Overview:
- Serial-to-parallel front end that sits directly upstream of the single-port RAM stage.
- Deserialises MOSI frames into (ADDR_SIZE+2)-bit command words and pulses rx_valid to the RAM.
- On read-data commands, takes the RAM's tx_data/tx_valid response and serialises it MSB-first onto MISO.
- Runs synchronous to clk, which is the SPI serial clock, with SS_n as an active-low frame select.

Parameters:
- ADDR_SIZE, 8, width of the address/data payload. Frame width is ADDR_SIZE+2 bits.
- TIMEOUT_CYCLES, 15, maximum wait for tx_valid in READ_DATA. Used only with SPI_TX_TIMEOUT_EN.

Ports:
- clk  input  1  serial/system clock, rising-edge active
- rst_n  input  1  reset, asynchronous, active-low
- SS_n  input  1  slave select, active-low; high aborts any frame
- MOSI  input  1  serial data in, sampled on rising clk
- tx_data  input  ADDR_SIZE  read data from RAM
- tx_valid  input  1  RAM read data valid; level, may stay high for many cycles
- MISO  output  1  serial data out, registered
- rx_data  output  ADDR_SIZE+2  received frame {cmd[1:0], payload}
- rx_valid  output  1  one-cycle pulse, rx_data valid
- timeout_err  output  1  present only with SPI_TX_TIMEOUT_EN

Behaviour:
- Reset (async, rst_n=0) sets: state=IDLE, MISO=0, rx_data=0, rx_valid=0, bit counter=0, rd_addr_seen=0, tx_latched=0, timeout_err=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. Encoding is free; the state register is one-hot or binary.
- IDLE: stays while SS_n=1. SS_n=0 goes to CHK_CMD on the next edge. MOSI is not sampled in IDLE.
- CHK_CMD: samples MOSI as frame bit [ADDR_SIZE+1] (MSB) and sets counter=1.
  - MOSI=0 goes to WRITE.
  - MOSI=1 with rd_addr_seen=0 goes to READ_ADD.
  - MOSI=1 with rd_addr_seen=1 goes to READ_DATA.
- WRITE, READ_ADD, READ_DATA, receive phase:
  - Shifts MOSI in MSB-first, one bit per clk, and increments the counter.
  - The edge that captures bit 0 (counter reaches ADDR_SIZE+2) loads rx_data with the full frame.
  - rx_valid is high for exactly the following cycle.
  - rx_valid is never asserted for a partial frame.
- After rx_valid, WRITE and READ_ADD hold their state, ignore MOSI and keep MISO=0 until SS_n=1, then return to IDLE.
- READ_ADD sets rd_addr_seen=1 on the rx_valid cycle.
- READ_DATA, transmit phase (after rx_valid):
  - Waits for tx_valid=1 and captures tx_data once, setting tx_latched=1. tx_valid is ignored while tx_latched=1.
  - MISO drives tx_data[ADDR_SIZE-1] through tx_data[0] on the ADDR_SIZE consecutive cycles starting the cycle after capture.
  - MISO then returns to 0.
  - rd_addr_seen and tx_latched clear when the last bit has been driven.
- SS_n=1 in any non-IDLE state:
  - Next state is IDLE; the counter clears and MISO=0.
  - No rx_valid is generated. A partial frame is discarded.
  - rd_addr_seen is kept unless the transmit phase has completed.
- Simultaneous events:
  - tx_valid already high on the rx_valid cycle is captured on the following cycle, not earlier.
  - SS_n rising on the same edge as bit-0 capture is an abort: no rx_valid.
- rx_data holds its last value between frames and is not cleared by an abort.

Optional Feature:
- Macro: SPI_TX_TIMEOUT_EN.
- Defined:
  - Adds the timeout_err port and a wait counter that runs in READ_DATA from the rx_valid cycle until tx_valid is captured.
  - If the counter reaches TIMEOUT_CYCLES, timeout_err is set (sticky) and the FSM stops waiting. MISO stays 0.
  - rd_addr_seen and tx_latched clear, and the FSM stays in READ_DATA until SS_n=1.
  - timeout_err clears only on reset or on the next CHK_CMD entry.
- Not defined: no port, no counter; READ_DATA waits for tx_valid indefinitely.

Test Plan:
- Write pair:
  - Stimulus: SS_n low, MOSI frame 10'b00_1010_0101, SS_n high; then frame 10'b01_0011_1100.
  - Response: rx_valid pulses once per frame, with rx_data=0x0A5 then 0x13C. MISO stays 0.
- Read address then read data:
  - Stimulus: frame 10'b10_0000_0111. Then frame 10'b11_xxxx_xxxx, with tx_valid=1 and tx_data=0xC3 one cycle after rx_valid.
  - Response: the first frame routes to READ_ADD. The second routes to READ_DATA. MISO=1,1,0,0,0,0,1,1 then 0.
- Abort:
  - Stimulus: SS_n high after 6 bits of a WRITE frame.
  - Response: no rx_valid, state returns to IDLE, and the next full frame 0x0FF decodes correctly.
- Held tx_valid:
  - Stimulus: tx_valid held high for 20 cycles during READ_DATA.
  - Response: exactly 8 MISO data bits. tx_data changed to 0x00 mid-shift does not alter the output.
- Reset mid-transmit:
  - Stimulus: rst_n low after the 3rd MISO bit.
  - Response: MISO=0, rx_valid=0, IDLE, and rd_addr_seen=0, so the next MOSI=1 frame goes to READ_ADD.
- Timeout (SPI_TX_TIMEOUT_EN defined):
  - Stimulus: no tx_valid after a READ_DATA frame.
  - Response: timeout_err=1 after 15 cycles, MISO stays 0, and the next CHK_CMD clears timeout_err.
